// File: rtl/tmr_lane_monitor.sv
// rtl/tmr_lane_monitor.sv - triplicated-bus splitter with majority vote and per-lane health tracking
//
// Splits a 3*WIDTH triplicated bus into three registered lanes, votes them bitwise
// and keeps per-lane statistics: saturating error counts and an OK/SUSPECT/FAULTY
// state machine per lane.
//
// Ports:
//   clk                      rising-edge clock
//   resetn                   asynchronous active-low reset
//   vector_in[3*WIDTH-1:0]   lane0 in the low WIDTH bits, lane2 in the high WIDTH bits
//   valid_in                 vector_in is meaningful this cycle
//   clr                      synchronous clear of counters, lane FSMs and triple_fail
//   signal_out0..2           registered lanes
//   voted_out                registered bitwise majority
//   valid_out                valid_in delayed one cycle
//   mismatch[2:0]            registered: lane i differed from the majority
//   triple_fail              sticky: all three lanes pairwise different on some valid sample
//   err_cnt0..2              saturating count of valid samples where lane i mismatched
//   lane_faulty[2:0]         lane i FSM is FAULTY

module tmr_lane_monitor #(
    parameter int WIDTH  = 1,
    parameter int CNT_W  = 8,
    parameter int THRESH = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [3*WIDTH-1:0] vector_in,
    input  logic               valid_in,
    input  logic               clr,
    output logic [WIDTH-1:0]   signal_out0,
    output logic [WIDTH-1:0]   signal_out1,
    output logic [WIDTH-1:0]   signal_out2,
    output logic [WIDTH-1:0]   voted_out,
    output logic               valid_out,
    output logic [2:0]         mismatch,
    output logic               triple_fail,
    output logic [CNT_W-1:0]   err_cnt0,
    output logic [CNT_W-1:0]   err_cnt1,
    output logic [CNT_W-1:0]   err_cnt2,
    output logic [2:0]         lane_faulty
);

    // Run counter only has to reach THRESH; FAULTY is sticky so it never goes past it.
    localparam int RUN_W = (THRESH < 2) ? 1 : $clog2(THRESH + 1);
    localparam logic [RUN_W-1:0] THRESH_R = RUN_W'(THRESH);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULTY  = 2'd2
    } lane_state_t;

    logic [2:0][WIDTH-1:0] lane;
    logic [WIDTH-1:0]      voted_c;
    logic [2:0]            mism_c;
    logic                  triple_c;
    logic [2:0][WIDTH-1:0] lane_q;
    logic [3*CNT_W-1:0]    cnt_all;

    assign lane = vector_in;

    always_comb begin
        voted_c = (lane[0] & lane[1]) | (lane[1] & lane[2]) | (lane[0] & lane[2]);
        for (int i = 0; i < 3; i++) begin
            mism_c[i] = |(lane[i] ^ voted_c);
        end
        triple_c = (lane[0] != lane[1]) && (lane[1] != lane[2]) && (lane[0] != lane[2]);
    end

    // Data path: ignores clr, holds on invalid cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lane_q    <= '0;
            voted_out <= '0;
            mismatch  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                lane_q    <= lane;
                voted_out <= voted_c;
                mismatch  <= mism_c;
            end
        end
    end

    assign signal_out0 = lane_q[0];
    assign signal_out1 = lane_q[1];
    assign signal_out2 = lane_q[2];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            triple_fail <= 1'b0;
        end else if (clr) begin
            triple_fail <= 1'b0;
        end else if (valid_in && triple_c) begin
            triple_fail <= 1'b1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_lane
        lane_state_t      state_q, state_d;
        logic [RUN_W-1:0] run_q, run_d;
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cnt_q <= '0;
            end else if (clr) begin
                cnt_q <= '0;
            end else if (valid_in && mism_c[g] && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q <= ST_OK;
                run_q   <= '0;
            end else if (clr) begin
                state_q <= ST_OK;
                run_q   <= '0;
            end else begin
                state_q <= state_d;
                run_q   <= run_d;
            end
        end

        always_comb begin
            state_d = state_q;
            run_d   = run_q;
            if (valid_in) begin
                case (state_q)
                    ST_OK: begin
                        if (mism_c[g]) begin
                            run_d   = RUN_ONE;
                            state_d = (THRESH == 1) ? ST_FAULTY : ST_SUSPECT;
                        end
                    end
                    ST_SUSPECT: begin
                        if (mism_c[g]) begin
                            run_d = run_q + 1'b1;
                            if (run_d == THRESH_R) begin
                                state_d = ST_FAULTY;
                            end
                        end else begin
                            run_d   = '0;
                            state_d = ST_OK;
                        end
                    end
                    ST_FAULTY: begin
                        state_d = ST_FAULTY;
                    end
                    default: begin
                        state_d = ST_OK;
                        run_d   = '0;
                    end
                endcase
            end
        end

        assign lane_faulty[g]                 = (state_q == ST_FAULTY);
        assign cnt_all[g*CNT_W +: CNT_W]      = cnt_q;
    end

    assign err_cnt0 = cnt_all[0*CNT_W +: CNT_W];
    assign err_cnt1 = cnt_all[1*CNT_W +: CNT_W];
    assign err_cnt2 = cnt_all[2*CNT_W +: CNT_W];

endmodule

// File: tb/tb_tmr_lane_monitor.sv
// tb/tb_tmr_lane_monitor.sv - scoreboard bench for tmr_lane_monitor (CNT_W=8 and CNT_W=2 instances)

module tb_tmr_lane_monitor;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic [3*W-1:0] vector_in;
    logic          valid_in;
    logic          clr;

    logic [W-1:0]  a_s0, a_s1, a_s2, a_voted;
    logic          a_valid, a_triple;
    logic [2:0]    a_mism, a_faulty;
    logic [7:0]    a_c0, a_c1, a_c2;

    logic [W-1:0]  b_s0, b_s1, b_s2, b_voted;
    logic          b_valid, b_triple;
    logic [2:0]    b_mism, b_faulty;
    logic [1:0]    b_c0, b_c1, b_c2;

    always #5 clk = ~clk;

    tmr_lane_monitor #(.WIDTH(W), .CNT_W(8), .THRESH(4)) dut_a (
        .clk(clk), .resetn(resetn), .vector_in(vector_in), .valid_in(valid_in), .clr(clr),
        .signal_out0(a_s0), .signal_out1(a_s1), .signal_out2(a_s2), .voted_out(a_voted),
        .valid_out(a_valid), .mismatch(a_mism), .triple_fail(a_triple),
        .err_cnt0(a_c0), .err_cnt1(a_c1), .err_cnt2(a_c2), .lane_faulty(a_faulty)
    );

    tmr_lane_monitor #(.WIDTH(W), .CNT_W(2), .THRESH(4)) dut_b (
        .clk(clk), .resetn(resetn), .vector_in(vector_in), .valid_in(valid_in), .clr(clr),
        .signal_out0(b_s0), .signal_out1(b_s1), .signal_out2(b_s2), .voted_out(b_voted),
        .valid_out(b_valid), .mismatch(b_mism), .triple_fail(b_triple),
        .err_cnt0(b_c0), .err_cnt1(b_c1), .err_cnt2(b_c2), .lane_faulty(b_faulty)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] l0, l1, l2, v;
        logic [2:0] mm;
    } exp_t;

    exp_t sb[$];
    exp_t last;

    // Reference model: per-lane consecutive-mismatch run, FAULTY once the run reaches 4.
    int m_cnt_a [3];
    int m_cnt_b [3];
    int m_run   [3];
    bit m_faulty[3];
    bit m_triple;

    function automatic logic [7:0] maj(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) begin
            int n;
            n = int'(a[k]) + int'(b[k]) + int'(c[k]);
            r[k] = (n >= 2);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt_a[i] = 0; m_cnt_b[i] = 0; m_run[i] = 0; m_faulty[i] = 0;
        end
        m_triple = 0;
        sb.delete();
        last = '{l0: 8'h00, l1: 8'h00, l2: 8'h00, v: 8'h00, mm: 3'b000};
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {a_valid, b_valid}, 0);
        check({tag, "_voted"}, {a_voted, b_voted}, 0);
        check({tag, "_sig"},   {a_s0, a_s1, a_s2, b_s0}, 0);
        check({tag, "_mism"},  {a_mism, b_mism}, 0);
        check({tag, "_cnt"},   {a_c0, a_c1, a_c2, b_c0, b_c1, b_c2}, 0);
        check({tag, "_flt"},   {a_faulty, b_faulty, a_triple, b_triple}, 0);
    endtask

    task automatic step(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                        input bit v, input bit c);
        logic [7:0] l [3];
        logic [7:0] vt;
        logic [2:0] mm;
        @(negedge clk);
        vector_in = {l2, l1, l0};
        valid_in  = v;
        clr       = c;
        l[0] = l0; l[1] = l1; l[2] = l2;
        vt = maj(l0, l1, l2);
        for (int i = 0; i < 3; i++) mm[i] = (l[i] != vt);
        if (v) sb.push_back('{l0: l0, l1: l1, l2: l2, v: vt, mm: mm});
        if (c) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt_a[i] = 0; m_cnt_b[i] = 0; m_run[i] = 0; m_faulty[i] = 0;
            end
            m_triple = 0;
        end else if (v) begin
            for (int i = 0; i < 3; i++) begin
                if (mm[i]) begin
                    if (m_cnt_a[i] < 255) m_cnt_a[i]++;
                    if (m_cnt_b[i] < 3)   m_cnt_b[i]++;
                    m_run[i]++;
                end else begin
                    m_run[i] = 0;
                end
                if (m_run[i] >= 4) m_faulty[i] = 1;
            end
            if (l0 != l1 && l1 != l2 && l0 != l2) m_triple = 1;
        end
        @(posedge clk);
        #1;
        check("valid_out", {a_valid, b_valid}, {v, v});
        if (a_valid) begin
            check("sb_size", sb.size(), (sb.size() == 0) ? 1 : sb.size());
            if (sb.size() != 0) last = sb.pop_front();
        end
        check("lanes_a",  {a_s0, a_s1, a_s2}, {last.l0, last.l1, last.l2});
        check("lanes_b",  {b_s0, b_s1, b_s2}, {last.l0, last.l1, last.l2});
        check("voted",    {a_voted, b_voted}, {last.v, last.v});
        check("mismatch", {a_mism, b_mism}, {last.mm, last.mm});
        check("err_cnt_a", {a_c0, a_c1, a_c2}, {m_cnt_a[0][7:0], m_cnt_a[1][7:0], m_cnt_a[2][7:0]});
        check("err_cnt_b", {b_c0, b_c1, b_c2}, {m_cnt_b[0][1:0], m_cnt_b[1][1:0], m_cnt_b[2][1:0]});
        check("lane_faulty", {a_faulty, b_faulty},
              {m_faulty[2], m_faulty[1], m_faulty[0], m_faulty[2], m_faulty[1], m_faulty[0]});
        check("triple_fail", {a_triple, b_triple}, {m_triple, m_triple});
    endtask

    initial begin
        resetn    = 1'b0;
        valid_in  = 1'b0;
        clr       = 1'b0;
        vector_in = '0;
        model_reset();
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // 1: all lanes agree
        step(8'hA5, 8'hA5, 8'hA5, 1, 0);
        // 2: lane1 wrong four times in a row -> FAULTY on the 4th
        repeat (4) step(8'hFF, 8'h00, 8'hFF, 1, 0);
        // invalid cycles with garbage do not touch stats or data
        repeat (2) step(8'h12, 8'h34, 8'h56, 0, 0);
        step(8'h00, 8'h00, 8'h00, 1, 1);
        // 3: lane2 run broken by one clean sample
        repeat (3) step(8'h00, 8'h00, 8'hFF, 1, 0);
        step(8'h3C, 8'h3C, 8'h3C, 1, 0);
        repeat (3) step(8'h00, 8'h00, 8'hFF, 1, 0);
        step(8'h00, 8'h00, 8'h00, 1, 1);
        // 4: lane0 bad 10 cycles, CNT_W=2 instance saturates at 3
        repeat (10) step(8'h0F, 8'hF0, 8'hF0, 1, 0);
        // clr coincident with a saturating mismatch: stats to 0, data captured
        step(8'h0F, 8'hF0, 8'hF0, 1, 1);
        // 5: no majority on any lane
        step(8'h01, 8'h02, 8'h04, 1, 0);
        repeat (3) step(8'h77, 8'h77, 8'h77, 1, 0);
        step(8'h77, 8'h77, 8'h77, 0, 1);
        // 6: mixed traffic with gaps, then async reset mid-run
        for (int n = 0; n < 30; n++) begin
            logic [7:0] base, e;
            int sel;
            base = 8'($urandom);
            e    = 8'($urandom_range(1, 255));
            sel  = $urandom_range(0, 3);
            step((sel == 0) ? base ^ e : base, (sel == 1) ? base ^ e : base,
                 (sel == 2) ? base ^ e : base, ($urandom_range(0, 3) != 0), 0);
        end
        repeat (5) step(8'hAA, 8'h55, 8'hAA, 1, 0);
        #2;
        resetn = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        valid_in  = 1'b1;
        vector_in = {8'hFF, 8'h00, 8'hFF};
        @(posedge clk);
        #1;
        check_zero("rst_held");
        @(negedge clk);
        valid_in = 1'b0;
        resetn   = 1'b1;
        repeat (2) step(8'h00, 8'h81, 8'h81, 1, 0);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
